msrv32_machine_control: RTL and testbench
=========================================

MSRV32_MACHINE_CONTROL -- requirements
Module: msrv32_machine_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
- ms_riscv32_mp_clk_in  input  1  clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
REQ-002 SHALL have these inputs:
- illegal_instr_in  input  1  decoder flag: illegal instruction.
- misaligned_load_in  input  1  decoder flag: misaligned load.
- misaligned_store_in  input  1  decoder flag: misaligned store.
- misaligned_instr_in  input  1  fetch flag: PC misaligned.
- opcode_6_to_2_in  input  5  instruction opcode bits [6:2].
- funct3_in  input  3  instruction funct3.
- funct7_in  input  7  instruction funct7.
- rs1_addr_in / rs2_addr_in / rd_addr_in  input  5 each  instruction register fields.
- mie_in  input  1  global machine interrupt enable.
- meie_in / mtie_in / msie_in  input  1 each  external / timer / software interrupt enables.
- meip_in / mtip_in / msip_in  input  1 each  external / timer / software interrupt pending.
REQ-003 SHALL have these outputs:
- trap_taken_out  output  1  combinational; suppresses decoder memory write and register write this cycle.
- pc_src_out  output  2  PC select: 00 BOOT, 01 NEXT, 10 EPC, 11 TRAP.
- flush_out  output  1  flush fetched instruction.
- set_epc_out / set_cause_out  output  1 each  CSR update strobes.
- cause_out  output  4  registered trap cause code.
- i_or_e_out  output  1  registered; 1 = interrupt, 0 = exception.
- mie_clear_out / mie_set_out  output  1 each  MIE/MPIE update strobes.
- misaligned_exception_out  output  1  registered; 1 when cause is 0, 4 or 6 and the trap is an exception.
- instret_inc_out  output  1  instruction-retired strobe.

Function
REQ-004 SHALL implement a 2-bit state register with states RESET=00, OPERATING=01, TRAP_TAKEN=10, TRAP_RETURN=11.
REQ-005 SHALL make the following transitions:
- RESET -> OPERATING unconditionally.
- OPERATING -> TRAP_TAKEN if take_trap; else -> TRAP_RETURN if is_mret; else stay in OPERATING.
- TRAP_TAKEN -> OPERATING.
- TRAP_RETURN -> OPERATING.
REQ-006 SHALL decode when opcode_6_to_2_in=11100, funct3_in=000, rs1_addr_in=0 and rd_addr_in=0:
- ecall: funct7_in=0000000, rs2_addr_in=00000.
- ebreak: funct7_in=0000000, rs2_addr_in=00001.
- mret: funct7_in=0011000, rs2_addr_in=00010.
REQ-007 SHALL define exception = misaligned_instr | illegal_instr | is_ebreak | is_ecall | misaligned_load | misaligned_store.
REQ-008 SHALL define irq = mie_in & ((meie_in&meip_in) | (msie_in&msip_in) | (mtie_in&mtip_in)).
REQ-009 SHALL define take_trap = exception | irq; an exception SHALL win over a simultaneous interrupt.
REQ-010 SHALL select the exception cause by fixed priority: misaligned_instr 0 > illegal 2 > ebreak 3 > ecall 11 > misaligned_load 4 > misaligned_store 6.
REQ-011 SHALL select the interrupt cause by fixed priority: external 11 > software 3 > timer 7.
REQ-012 SHALL capture cause_out, i_or_e_out and misaligned_exception_out only on the OPERATING->TRAP_TAKEN edge, and hold them otherwise.
REQ-013 SHALL assert trap_taken_out = (state==OPERATING) & take_trap, combinationally.
REQ-014 SHALL drive outputs per state:
- RESET: pc_src 00, flush 1, all strobes 0.
- OPERATING: pc_src 01, flush 0, instret_inc_out = ~take_trap.
- TRAP_TAKEN: pc_src 11, flush 1, set_epc 1, set_cause 1, mie_clear 1.
- TRAP_RETURN: pc_src 10, flush 1, mie_set 1.
REQ-015 SHALL not detect traps in TRAP_TAKEN or TRAP_RETURN; flags present in those states SHALL be ignored.
REQ-016 SHALL give mret in OPERATING with a simultaneous take_trap to the trap; mret SHALL be lost.
REQ-017 SHALL have a trap latency of exactly one cycle: flag in cycle N gives TRAP_TAKEN strobes in cycle N+1 and OPERATING in cycle N+2.

Reset
REQ-018 SHALL, with reset high at a clock edge, move to RESET regardless of current state, including mid-TRAP_TAKEN.
REQ-019 SHALL clear cause_out=0, i_or_e_out=0 and misaligned_exception_out=0 on reset.
REQ-020 SHALL, while reset is high, drive pc_src_out=00, flush_out=1 and all strobes and trap_taken_out=0.
REQ-021 SHALL reach OPERATING on the first edge after reset is released.

Verification
REQ-022 Reset release: reset low -> RESET one cycle (pc_src 00) -> OPERATING (pc_src 01, instret_inc 1).
REQ-023 Illegal + pending timer irq (mie=1, mtie=1, mtip=1, illegal=1): trap_taken 1 same cycle; next cycle cause 2, i_or_e 0, set_epc 1, set_cause 1, pc_src 11.
REQ-024 Interrupt priority (meip=msip=mtip=1, all enables 1, no exception): cause 11, i_or_e 1; repeat with meip=0 -> cause 3.
REQ-025 mret (funct7 0011000, rs2 00010, opcode 11100): TRAP_RETURN, mie_set 1, pc_src 10, flush 1, then OPERATING.
REQ-026 Misaligned store (misaligned_store=1): cause 6, misaligned_exception 1, trap_taken 1 in the flag cycle.
REQ-027 Reset asserted during TRAP_TAKEN: next state RESET, cause 0, no further strobes.

Source files
------------

// File: rtl/msrv32_machine_control_if.sv
// Trap/interrupt control bundle between the decode/CSR datapath (master)
// and the machine-mode control FSM (slave).
interface msrv32_machine_control_if;
  logic       illegal_instr_in;
  logic       misaligned_load_in;
  logic       misaligned_store_in;
  logic       misaligned_instr_in;
  logic [4:0] opcode_6_to_2_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [4:0] rs1_addr_in;
  logic [4:0] rs2_addr_in;
  logic [4:0] rd_addr_in;
  logic       mie_in;
  logic       meie_in;
  logic       mtie_in;
  logic       msie_in;
  logic       meip_in;
  logic       mtip_in;
  logic       msip_in;

  logic       trap_taken_out;
  logic [1:0] pc_src_out;
  logic       flush_out;
  logic       set_epc_out;
  logic       set_cause_out;
  logic [3:0] cause_out;
  logic       i_or_e_out;
  logic       mie_clear_out;
  logic       mie_set_out;
  logic       misaligned_exception_out;
  logic       instret_inc_out;

  modport master (
    output illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
    output opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
    output mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    input  trap_taken_out, pc_src_out, flush_out, set_epc_out, set_cause_out, cause_out,
    input  i_or_e_out, mie_clear_out, mie_set_out, misaligned_exception_out, instret_inc_out
  );

  modport slave (
    input  illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
    input  opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
    input  mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in,
    output trap_taken_out, pc_src_out, flush_out, set_epc_out, set_cause_out, cause_out,
    output i_or_e_out, mie_clear_out, mie_set_out, misaligned_exception_out, instret_inc_out
  );
endinterface

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap controller: detects exceptions/interrupts, sequences
// trap entry and mret return, and latches the trap cause for the CSR file.
//
//   state       | meaning
//   RESET       | boot; PC from boot vector, pipeline flushed
//   OPERATING   | normal execution, trap/mret detection active
//   TRAP_TAKEN  | trap entry; PC from trap vector, EPC/cause written, MIE cleared
//   TRAP_RETURN | mret; PC from EPC, MIE restored from MPIE
module msrv32_machine_control (
  input  logic ms_riscv32_mp_clk_in,
  input  logic ms_riscv32_mp_rst_in,
  msrv32_machine_control_if.slave ctl
);

  typedef enum logic [1:0] {
    RESET       = 2'b00,
    OPERATING   = 2'b01,
    TRAP_TAKEN  = 2'b10,
    TRAP_RETURN = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cause_q;
  logic       i_or_e_q;
  logic       misaligned_q;

  logic       is_system, is_ecall, is_ebreak, is_mret;
  logic       exception, irq, take_trap;
  logic [3:0] exc_cause, irq_cause, trap_cause;
  logic       trap_misaligned;

  assign is_system = (ctl.opcode_6_to_2_in == 5'b11100) && (ctl.funct3_in == 3'b000) &&
                     (ctl.rs1_addr_in == 5'd0) && (ctl.rd_addr_in == 5'd0);
  assign is_ecall  = is_system && (ctl.funct7_in == 7'b0000000) && (ctl.rs2_addr_in == 5'b00000);
  assign is_ebreak = is_system && (ctl.funct7_in == 7'b0000000) && (ctl.rs2_addr_in == 5'b00001);
  assign is_mret   = is_system && (ctl.funct7_in == 7'b0011000) && (ctl.rs2_addr_in == 5'b00010);

  assign exception = ctl.misaligned_instr_in | ctl.illegal_instr_in | is_ebreak | is_ecall |
                     ctl.misaligned_load_in | ctl.misaligned_store_in;
  assign irq       = ctl.mie_in & ((ctl.meie_in & ctl.meip_in) |
                                   (ctl.msie_in & ctl.msip_in) |
                                   (ctl.mtie_in & ctl.mtip_in));
  assign take_trap = exception | irq;

  always_comb begin
    exc_cause = 4'd0;
    if (ctl.misaligned_instr_in)      exc_cause = 4'd0;
    else if (ctl.illegal_instr_in)    exc_cause = 4'd2;
    else if (is_ebreak)               exc_cause = 4'd3;
    else if (is_ecall)                exc_cause = 4'd11;
    else if (ctl.misaligned_load_in)  exc_cause = 4'd4;
    else if (ctl.misaligned_store_in) exc_cause = 4'd6;
  end

  always_comb begin
    irq_cause = 4'd0;
    if (ctl.meie_in & ctl.meip_in)      irq_cause = 4'd11;
    else if (ctl.msie_in & ctl.msip_in) irq_cause = 4'd3;
    else if (ctl.mtie_in & ctl.mtip_in) irq_cause = 4'd7;
  end

  // Exceptions outrank interrupts arriving in the same cycle.
  assign trap_cause      = exception ? exc_cause : irq_cause;
  assign trap_misaligned = exception &&
                           (exc_cause == 4'd0 || exc_cause == 4'd4 || exc_cause == 4'd6);

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q      <= RESET;
      cause_q      <= 4'd0;
      i_or_e_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == OPERATING && take_trap) begin
        cause_q      <= trap_cause;
        i_or_e_q     <= ~exception;
        misaligned_q <= trap_misaligned;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    ctl.trap_taken_out = 1'b0;
    ctl.pc_src_out     = 2'b00;
    ctl.flush_out      = 1'b1;
    ctl.set_epc_out    = 1'b0;
    ctl.set_cause_out  = 1'b0;
    ctl.mie_clear_out  = 1'b0;
    ctl.mie_set_out    = 1'b0;
    ctl.instret_inc_out = 1'b0;
    case (state_q)
      RESET: state_d = OPERATING;
      OPERATING: begin
        ctl.pc_src_out      = 2'b01;
        ctl.flush_out       = 1'b0;
        ctl.trap_taken_out  = take_trap;
        ctl.instret_inc_out = ~take_trap;
        // A trap in the same cycle as mret wins; the mret is dropped.
        if (take_trap)    state_d = TRAP_TAKEN;
        else if (is_mret) state_d = TRAP_RETURN;
      end
      TRAP_TAKEN: begin
        ctl.pc_src_out    = 2'b11;
        ctl.set_epc_out   = 1'b1;
        ctl.set_cause_out = 1'b1;
        ctl.mie_clear_out = 1'b1;
        state_d           = OPERATING;
      end
      TRAP_RETURN: begin
        ctl.pc_src_out  = 2'b10;
        ctl.mie_set_out = 1'b1;
        state_d         = OPERATING;
      end
      default: state_d = RESET;
    endcase
    if (ms_riscv32_mp_rst_in) begin
      ctl.trap_taken_out  = 1'b0;
      ctl.pc_src_out      = 2'b00;
      ctl.flush_out       = 1'b1;
      ctl.set_epc_out     = 1'b0;
      ctl.set_cause_out   = 1'b0;
      ctl.mie_clear_out   = 1'b0;
      ctl.mie_set_out     = 1'b0;
      ctl.instret_inc_out = 1'b0;
    end
  end

  assign ctl.cause_out                = cause_q;
  assign ctl.i_or_e_out               = i_or_e_q;
  assign ctl.misaligned_exception_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Bench for msrv32_machine_control: directed vector table, hand-written
// multi-cycle sequences and randomized cycles against a behavioural model.
module tb_msrv32_machine_control;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  msrv32_machine_control_if bus();

  msrv32_machine_control dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .ctl(bus)
  );

  typedef struct packed {
    logic       mins, ill, mld, mst;
    logic [4:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;
    logic       mie, meie, msie, mtie, meip, msip, mtip;
  } in_t;

  // exc = {mins, ill, mld, mst}; sys: 0 none, 1 ecall, 2 ebreak, 3 mret;
  // irq = {mie, meie, msie, mtie, meip, msip, mtip}
  typedef struct packed {
    logic [3:0] exc;
    logic [1:0] sys;
    logic [6:0] irq;
    logic       tt;
    logic [3:0] cause;
    logic       ie;
    logic       mis;
  } vec_t;

  // Output vector: [14] trap_taken [13:12] pc_src [11] flush [10] set_epc
  // [9] set_cause [8] mie_clear [7] mie_set [6] instret [5:2] cause [1] i_or_e [0] mis
  int checks = 0;
  int errors = 0;

  int         m_phase;   // 0 boot, 1 running, 2 entering trap, 3 returning
  logic [3:0] m_cause;
  logic       m_ie, m_mis;

  function automatic in_t idle();
    in_t x;
    x = '0;
    x.op = 5'b01100;
    return x;
  endfunction

  function automatic in_t with_sys(input in_t xi, input int k);
    in_t x;
    x = xi;
    if (k != 0) begin
      x.op = 5'b11100; x.f3 = 3'b000; x.rs1 = 5'd0; x.rd = 5'd0;
      x.f7  = (k == 3) ? 7'b0011000 : 7'b0000000;
      x.rs2 = (k == 1) ? 5'd0 : (k == 2) ? 5'd1 : 5'd2;
    end
    return x;
  endfunction

  function automatic in_t from_vec(input vec_t v);
    in_t x;
    x = idle();
    {x.mins, x.ill, x.mld, x.mst} = v.exc;
    {x.mie, x.meie, x.msie, x.mtie, x.meip, x.msip, x.mtip} = v.irq;
    return with_sys(x, int'(v.sys));
  endfunction

  function automatic int sys_kind(input in_t x);
    if (x.op != 5'b11100 || x.f3 != 0 || x.rs1 != 0 || x.rd != 0) return 0;
    if (x.f7 == 7'd0 && x.rs2 == 5'd0) return 1;
    if (x.f7 == 7'd0 && x.rs2 == 5'd1) return 2;
    if (x.f7 == 7'b0011000 && x.rs2 == 5'd2) return 3;
    return 0;
  endfunction

  // First matching source in priority order decides the cause.
  function automatic void trap_info(input in_t x, output logic t, output logic [3:0] c,
                                    output logic ie, output logic mis);
    logic e_src [6];
    int   e_code [6];
    logic i_src [3];
    int   i_code [3];
    int   k;
    k = sys_kind(x);
    e_src  = '{x.mins, x.ill, k == 2, k == 1, x.mld, x.mst};
    e_code = '{0, 2, 3, 11, 4, 6};
    i_src  = '{x.meie & x.meip, x.msie & x.msip, x.mtie & x.mtip};
    i_code = '{11, 3, 7};
    t = 0; c = 0; ie = 0; mis = 0;
    for (int i = 0; i < 6; i++)
      if (!t && e_src[i]) begin
        t = 1; c = 4'(e_code[i]); mis = (e_code[i] == 0 || e_code[i] == 4 || e_code[i] == 6);
      end
    if (!t && x.mie)
      for (int i = 0; i < 3; i++)
        if (!t && i_src[i]) begin t = 1; ie = 1; c = 4'(i_code[i]); end
  endfunction

  function automatic logic [14:0] model_out(input in_t x, input logic r);
    logic [14:0] e;
    logic t, ie, mis;
    logic [3:0] c;
    trap_info(x, t, c, ie, mis);
    e = '0;
    e[5:2] = m_cause; e[1] = m_ie; e[0] = m_mis;
    if (r) begin e[11] = 1; return e; end
    case (m_phase)
      0: e[11] = 1;
      1: begin e[13:12] = 2'b01; e[14] = t; e[6] = ~t; end
      2: begin e[13:12] = 2'b11; e[11] = 1; e[10] = 1; e[9] = 1; e[8] = 1; end
      default: begin e[13:12] = 2'b10; e[11] = 1; e[7] = 1; end
    endcase
    return e;
  endfunction

  function automatic void model_advance(input in_t x, input logic r);
    logic t, ie, mis;
    logic [3:0] c;
    trap_info(x, t, c, ie, mis);
    if (r) begin
      m_phase = 0; m_cause = 0; m_ie = 0; m_mis = 0;
    end else if (m_phase == 1) begin
      if (t) begin m_phase = 2; m_cause = c; m_ie = ie; m_mis = mis; end
      else if (sys_kind(x) == 3) m_phase = 3;
    end else m_phase = 1;
  endfunction

  task automatic drive(input in_t x);
    bus.misaligned_instr_in = x.mins; bus.illegal_instr_in = x.ill;
    bus.misaligned_load_in = x.mld;   bus.misaligned_store_in = x.mst;
    bus.opcode_6_to_2_in = x.op; bus.funct3_in = x.f3; bus.funct7_in = x.f7;
    bus.rs1_addr_in = x.rs1; bus.rs2_addr_in = x.rs2; bus.rd_addr_in = x.rd;
    bus.mie_in = x.mie; bus.meie_in = x.meie; bus.msie_in = x.msie; bus.mtie_in = x.mtie;
    bus.meip_in = x.meip; bus.msip_in = x.msip; bus.mtip_in = x.mtip;
  endtask

  function automatic logic [14:0] dut_vec();
    return {bus.trap_taken_out, bus.pc_src_out, bus.flush_out, bus.set_epc_out,
            bus.set_cause_out, bus.mie_clear_out, bus.mie_set_out, bus.instret_inc_out,
            bus.cause_out, bus.i_or_e_out, bus.misaligned_exception_out};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare at the falling edge, advance model at the rising edge.
  task automatic step(input in_t x, input logic r, input string name, output logic [14:0] act);
    drive(x);
    rst = r;
    @(negedge clk);
    act = dut_vec();
    chk(name, 32'(act), 32'(model_out(x, r)));
    @(posedge clk);
    model_advance(x, r);
    #1;
  endtask

  vec_t        vt [14];
  logic [14:0] a;
  in_t         x;

  initial begin
    vt[0]  = '{4'b0100, 2'd0, 7'b1001001, 1'b1, 4'd2,  1'b0, 1'b0};
    vt[1]  = '{4'b0000, 2'd0, 7'b1111111, 1'b1, 4'd11, 1'b1, 1'b0};
    vt[2]  = '{4'b0000, 2'd0, 7'b1111011, 1'b1, 4'd3,  1'b1, 1'b0};
    vt[3]  = '{4'b0000, 2'd0, 7'b1111001, 1'b1, 4'd7,  1'b1, 1'b0};
    vt[4]  = '{4'b0001, 2'd0, 7'b0000000, 1'b1, 4'd6,  1'b0, 1'b1};
    vt[5]  = '{4'b0011, 2'd0, 7'b0000000, 1'b1, 4'd4,  1'b0, 1'b1};
    vt[6]  = '{4'b0010, 2'd1, 7'b0000000, 1'b1, 4'd11, 1'b0, 1'b0};
    vt[7]  = '{4'b0010, 2'd2, 7'b0000000, 1'b1, 4'd3,  1'b0, 1'b0};
    vt[8]  = '{4'b1111, 2'd1, 7'b1111111, 1'b1, 4'd0,  1'b0, 1'b1};
    vt[9]  = '{4'b0000, 2'd0, 7'b0111111, 1'b0, 4'd0,  1'b0, 1'b0};
    vt[10] = '{4'b0000, 2'd0, 7'b1111000, 1'b0, 4'd0,  1'b0, 1'b0};
    vt[11] = '{4'b0000, 2'd0, 7'b1000111, 1'b0, 4'd0,  1'b0, 1'b0};
    vt[12] = '{4'b0000, 2'd1, 7'b1100100, 1'b1, 4'd11, 1'b0, 1'b0};
    vt[13] = '{4'b0000, 2'd3, 7'b0000000, 1'b0, 4'd0,  1'b0, 1'b0};

    drive(idle());
    rst = 1'b1;
    @(posedge clk); #1;
    m_phase = 0; m_cause = 0; m_ie = 0; m_mis = 0;

    // Reset held, then released: one boot cycle, then running.
    step(idle(), 1'b1, "reset_hold", a);
    chk("reset_outputs", 32'(a), 32'h0800);
    step(idle(), 1'b0, "boot", a);
    chk("boot_pc_src", 32'(a[13:12]), 32'h0);
    step(idle(), 1'b0, "first_op", a);
    chk("first_op_pc_instret", 32'({a[13:12], a[6]}), 32'b011);

    foreach (vt[i]) begin
      step(from_vec(vt[i]), 1'b0, "vec_flag", a);
      chk($sformatf("vec%0d_trap_taken", i), 32'(a[14]), 32'(vt[i].tt));
      step(idle(), 1'b0, "vec_next", a);
      if (vt[i].tt)
        chk($sformatf("vec%0d_cause_ie_mis_pc", i), 32'({a[5:0], a[13:12], a[10:9]}),
            32'({vt[i].cause, vt[i].ie, vt[i].mis, 2'b11, 2'b11}));
      step(idle(), 1'b0, "vec_settle", a);
    end

    // mret on its own: return cycle then back to running.
    step(with_sys(idle(), 3), 1'b0, "mret_issue", a);
    step(idle(), 1'b0, "mret_return", a);
    chk("mret_return_pc_set_flush", 32'({a[13:12], a[7], a[11]}), 32'b1011);
    step(idle(), 1'b0, "mret_after", a);
    chk("mret_after_pc", 32'(a[13:12]), 32'b01);

    // Flags during trap entry are ignored.
    x = idle(); x.ill = 1;
    step(x, 1'b0, "ign_flag", a);
    x = with_sys(idle(), 2); x.mst = 1;
    step(x, 1'b0, "ign_in_trap", a);
    chk("ign_tt_cause", 32'({a[14], a[5:2]}), 32'h02);
    step(idle(), 1'b0, "ign_back", a);
    chk("ign_back_pc", 32'(a[13:12]), 32'b01);

    // mret together with an interrupt: trap wins, mret dropped.
    x = with_sys(idle(), 3); x.mie = 1; x.meie = 1; x.meip = 1;
    step(x, 1'b0, "mret_irq", a);
    step(idle(), 1'b0, "mret_irq_next", a);
    chk("mret_irq_pc_cause", 32'({a[13:12], a[5:1]}), 32'({2'b11, 4'd11, 1'b1}));
    step(idle(), 1'b0, "mret_irq_settle", a);

    // Reset asserted while in trap entry.
    x = idle(); x.mins = 1;
    step(x, 1'b0, "rst_trap_flag", a);
    step(idle(), 1'b1, "rst_in_trap", a);
    chk("rst_in_trap_outputs", 32'(a[14:6]), 32'(9'b0_00_1_00000));
    step(idle(), 1'b0, "rst_after", a);
    chk("rst_after_state", 32'(a), 32'h0800);
    step(idle(), 1'b0, "rst_run", a);

    for (int n = 0; n < 600; n++) begin
      x = idle();
      x.mins = ($urandom_range(0, 11) == 0); x.ill = ($urandom_range(0, 9) == 0);
      x.mld  = ($urandom_range(0, 9) == 0);  x.mst = ($urandom_range(0, 9) == 0);
      x.mie  = $urandom_range(0, 1);
      x.meie = $urandom_range(0, 1); x.msie = $urandom_range(0, 1); x.mtie = $urandom_range(0, 1);
      x.meip = ($urandom_range(0, 3) == 0); x.msip = ($urandom_range(0, 3) == 0);
      x.mtip = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0: x = with_sys(x, 1);
        1: x = with_sys(x, 2);
        2: x = with_sys(x, 3);
        3: begin x = with_sys(x, int'($urandom_range(1, 3))); x.rd = 5'($urandom_range(1, 31)); end
        default: begin
          x.op = 5'($urandom); x.f3 = 3'($urandom); x.f7 = 7'($urandom);
          x.rs1 = 5'($urandom); x.rs2 = 5'($urandom); x.rd = 5'($urandom);
        end
      endcase
      step(x, ($urandom_range(0, 24) == 0), "random", a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
